quiescence_slot_responder: RTL

Per-slot endpoint of the quiescence protocol. It sits between one application slot and that slot's AMI memory port. It accepts quiesce, resume and check commands from the central quiescence controller. On a quiesce command it stops admitting new memory requests from the app and drains in-flight transactions. It answers check commands with a status word that reports whether the slot is fully quiesced.

---
 rtl/quiescence_slot_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/quiescence_slot_responder.sv
// Per-slot quiescence endpoint: gates app memory requests, tracks outstanding
// transactions, drains on quiesce and reports slot status on check commands.

package quiescence_slot_responder_pkg;

    typedef struct packed {
        logic        valid;
        logic        isRequest;
        logic [63:0] data;
    } QuiescenceReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } QuiescenceResp;

endpackage

module quiescence_slot_responder
    import quiescence_slot_responder_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  QuiescenceReq  quiescence_req,
    output QuiescenceResp quiescence_resp,
    input  logic          app_req_valid,
    output logic          app_req_grant,
    output logic          mem_req_valid,
    input  logic          mem_req_grant,
    input  logic          mem_resp_valid,
    input  logic          mem_resp_grant,
    output logic          quiesced
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        QUIESCED
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] count;
    logic [31:0]          drain_timer;
    logic                 timeout_flag;
    logic                 underflow_err;
    logic                 armed;

    logic                 accept;
    logic                 retire;
    logic                 check_fire;
    logic [63:0]          cnt_ext;
    logic [63:0]          status_word;
    logic                 unused_bits;

    // Request gating, transaction events and the status word built from registered state
    always_comb begin
        mem_req_valid  = app_req_valid && (state == RUN) && (count != '1);
        app_req_grant  = mem_req_grant && mem_req_valid;
        accept         = mem_req_valid && mem_req_grant;
        retire         = mem_resp_valid && mem_resp_grant;
        check_fire     = quiescence_req.valid && !quiescence_req.isRequest && armed;
        quiesced       = (state == QUIESCED);
        cnt_ext        = 64'(count);
        status_word    = '0;
        status_word[0] = (state == QUIESCED);
        status_word[1] = (state != RUN);
        status_word[2] = timeout_flag;
        status_word[3] = underflow_err;
        status_word[15:8] = cnt_ext[7:0];
        unused_bits    = ^{quiescence_req.data[63:1], cnt_ext[63:8]};
    end

    // Counter, drain timer, state machine, check handshake and response register
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            count           <= '0;
            drain_timer     <= '0;
            timeout_flag    <= 1'b0;
            underflow_err   <= 1'b0;
            armed           <= 1'b1;
            quiescence_resp <= '0;
        end else begin
            quiescence_resp.valid <= 1'b0;
            if (check_fire) begin
                quiescence_resp.valid <= 1'b1;
                quiescence_resp.data  <= status_word;
            end

            // The controller holds valid high while waiting, so re-arm only on idle cycles
            if (!quiescence_req.valid) begin
                armed <= 1'b1;
            end else if (check_fire) begin
                armed <= 1'b0;
            end

            if (accept && !retire) begin
                count <= count + 1'b1;
            end else if (retire && !accept) begin
                if (count == '0) begin
                    underflow_err <= 1'b1;
                end else begin
                    count <= count - 1'b1;
                end
            end

            if ((state == DRAIN) && (drain_timer != TIMEOUT_CYCLES)) begin
                drain_timer <= drain_timer + 32'd1;
            end
            if ((state == DRAIN) && (TIMEOUT_CYCLES != 0) && (drain_timer == TIMEOUT_CYCLES)) begin
                timeout_flag <= 1'b1;
            end

            if ((state == DRAIN) && (count == '0)) begin
                state <= QUIESCED;
            end

            // Commands are decoded last so a resume overrides the drain completion and timeout set
            if (quiescence_req.valid && quiescence_req.isRequest) begin
                if (quiescence_req.data[0]) begin
                    if (state == RUN) begin
                        state       <= DRAIN;
                        drain_timer <= '0;
                    end
                end else begin
                    state        <= RUN;
                    timeout_flag <= 1'b0;
                end
            end
        end
    end

endmodule
